load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: MEM_WORDS, default 64, number of 32-bit words in the downstream data memory; byte addresses >= 4*MEM_WORDS are out of range.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  CPU access request; sampled only when busy=0.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  store data, right-aligned.
REQ-009 busy  output  1  high while an accepted access is in progress.
REQ-010 rvalid  output  1  one-cycle pulse: access completed without fault; rdata valid if load.
REQ-011 rdata  output  32  extended load result, held until next load completes.
REQ-012 fault  output  1  one-cycle pulse: access rejected, no memory write performed.
REQ-013 mem_en, mem_we  output  1 each  data-memory enable / word write enable.
REQ-014 mem_a  output  32  word-aligned byte address to data memory (bits[1:0]=00).
REQ-015 mem_wd  output  32  word write data.
REQ-016 mem_rd  input  32  data-memory read word; valid at the rising edge ending the cycle in which mem_en=1.

Function
REQ-017 FSM states: IDLE, READ, WRITE, DONE; busy=1 in every state except IDLE.
REQ-018 IDLE: req_valid=1 captures req_we, funct3, addr, wdata; load or sub-word store -> READ; word store -> WRITE; faulting request -> DONE with fault pending.
REQ-019 READ: mem_en=1, mem_we=0, mem_a={addr[31:2],2'b00}; on exit mem_rd registered; load -> DONE, sub-word store -> WRITE.
REQ-020 WRITE: mem_we=1, mem_en=1; mem_wd = wdata (word) or read word with addressed byte/halfword lanes replaced by wdata[7:0]/[15:0]; -> DONE.
REQ-021 DONE: pulse rvalid or fault for exactly one cycle, -> IDLE; mem_en=mem_we=0.
REQ-022 Load extraction: lane selected by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W passes through.
REQ-023 Latency from accept edge to rvalid: load 2 cycles, SW 2 cycles, SB/SH 3 cycles (read-modify-write).
REQ-024 Faults: funct3 in {011,110,111}, store with funct3[2]=1, or addr >= 4*MEM_WORDS; no mem_en/mem_we asserted, rdata unchanged.
REQ-025 req_valid while busy=1 is ignored, not queued.
REQ-026 mem_en/mem_we/mem_a/mem_wd decode from state and registered fields only, never from live inputs.

Reset
REQ-027 rst=1 forces IDLE immediately without clock; busy, rvalid, fault, mem_en, mem_we = 0; rdata, mem_a, mem_wd = 0.
REQ-028 Reset during READ or WRITE aborts the access; a partially started RMW write is never issued; first rising edge after rst falls may accept a request.

Configuration
REQ-029 Macro LSU_MISALIGN_TRAP_EN defined: H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=00, fault per REQ-024.
REQ-030 Macro undefined: misalignment not checked; addr bits ignored below access size (H uses addr[1], W uses word), access proceeds normally.

Verification
REQ-031 Word 0x10 = 0x8899AABB; LB addr 0x13 -> rvalid 2 cycles after accept, rdata 0xFFFFFF88.
REQ-032 Same word; LHU addr 0x12 -> rdata 0x00008899; LH -> 0xFFFF8899.
REQ-033 Same word; SB addr 0x11 wdata 0x000000CC -> READ then WRITE with mem_wd 0x8899CCBB, single mem_we pulse, rvalid 3 cycles after accept.
REQ-034 LW addr 0x16: with LSU_MISALIGN_TRAP_EN -> fault pulse, no mem_en; without -> mem_a 0x14, rvalid.
REQ-035 SW addr 0x100 (MEM_WORDS=64) -> fault, mem_we never asserted.
REQ-036 rst pulsed mid-clock in WRITE -> mem_we and busy fall asynchronously, memory word unchanged; req_valid during busy before reset produces no second access.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: byte/halfword/word load-store front end for a single-port
// word-wide data memory. Sub-word stores are done as read-modify-write.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req_valid, req_we   access request (sampled only when idle), 1 = store
//   funct3              RISC-V width code (B, H, W, BU, HU)
//   addr, wdata         byte address, right-aligned store data
//   busy                access in progress
//   rvalid, fault       one-cycle completion / rejection pulses
//   rdata               extended load result, held until the next load
//   mem_en, mem_we      data-memory enable / word write enable
//   mem_a, mem_wd       word-aligned address / write word
//   mem_rd              read word, valid at the edge ending a mem_en cycle
//
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   -> misaligned H/HU/SH and W/SW accesses fault
//   undefined -> low address bits below the access size are ignored
//
// state | meaning
// IDLE  | waiting for req_valid
// READ  | memory read of the addressed word (load or RMW first half)
// WRITE | memory word write
// DONE  | rvalid or fault pulse, return to IDLE

module load_store_unit #(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        fault,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

    state_t      state_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  ofs_q;
    logic [15:0] wd_lo_q;
    logic        rvalid_q, fault_q, mem_en_q, mem_we_q;
    logic [31:0] rdata_q, mem_a_q, mem_wd_q;

    logic        bad_f3, out_of_range, misalign, req_fault;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] rdata_d, merge_d;

    assign bad_f3       = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    assign out_of_range = {1'b0, addr} >= MEM_BYTES;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Unsigned widths (funct3[2]=1) have no store encoding.
    assign req_fault = bad_f3 || (req_we && funct3[2]) || out_of_range || misalign;

    always_comb begin
        byte_sel = 8'h00;
        case (ofs_q)
            2'd0:    byte_sel = mem_rd[7:0];
            2'd1:    byte_sel = mem_rd[15:8];
            2'd2:    byte_sel = mem_rd[23:16];
            default: byte_sel = mem_rd[31:24];
        endcase
        half_sel = ofs_q[1] ? mem_rd[31:16] : mem_rd[15:0];

        rdata_d = mem_rd;
        case (f3_q)
            3'b000:  rdata_d = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  rdata_d = {24'h000000, byte_sel};
            3'b001:  rdata_d = {{16{half_sel[15]}}, half_sel};
            3'b101:  rdata_d = {16'h0000, half_sel};
            default: rdata_d = mem_rd;
        endcase

        merge_d = mem_rd;
        if (f3_q[1:0] == 2'b00) begin
            merge_d[{ofs_q, 3'b000} +: 8] = wd_lo_q[7:0];
        end else if (ofs_q[1]) begin
            merge_d[31:16] = wd_lo_q;
        end else begin
            merge_d[15:0] = wd_lo_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            f3_q     <= 3'b000;
            ofs_q    <= 2'b00;
            wd_lo_q  <= 16'h0000;
            rvalid_q <= 1'b0;
            fault_q  <= 1'b0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            rdata_q  <= 32'h0;
            mem_a_q  <= 32'h0;
            mem_wd_q <= 32'h0;
        end else begin
            rvalid_q <= 1'b0;
            fault_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= funct3;
                        ofs_q   <= addr[1:0];
                        wd_lo_q <= wdata[15:0];
                        if (req_fault) begin
                            fault_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            mem_a_q  <= {addr[31:2], 2'b00};
                            mem_en_q <= 1'b1;
                            if (req_we && (funct3[1:0] == 2'b10)) begin
                                mem_we_q <= 1'b1;
                                mem_wd_q <= wdata;
                                state_q  <= WRITE;
                            end else begin
                                state_q <= READ;
                            end
                        end
                    end
                end
                READ: begin
                    if (we_q) begin
                        mem_wd_q <= merge_d;
                        mem_we_q <= 1'b1;
                        state_q  <= WRITE;
                    end else begin
                        rdata_q  <= rdata_d;
                        mem_en_q <= 1'b0;
                        rvalid_q <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                WRITE: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    rvalid_q <= 1'b1;
                    state_q  <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = (state_q != IDLE);
    assign rvalid = rvalid_q;
    assign fault  = fault_q;
    assign rdata  = rdata_q;
    assign mem_en = mem_en_q;
    assign mem_we = mem_we_q;
    assign mem_a  = mem_a_q;
    assign mem_wd = mem_wd_q;

endmodule
